// File: rtl/arm_multicycle_datapath.sv
// Multicycle ARM datapath: PC, IR, MDR, A/B, ALUOut and a 15-entry register file.
// R15 reads return the live Result; the controller sequences everything via the control word.
module arm_multicycle_datapath #(
    parameter int WIDTH = 32,
    parameter int NREGS = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCWrite,
    input  logic             MemWrite,
    input  logic             RegWrite,
    input  logic             IRWrite,
    input  logic             AdrSrc,
    input  logic [1:0]       RegSrc,
    input  logic [1:0]       ALUSrcA,
    input  logic [1:0]       ALUSrcB,
    input  logic [1:0]       ResultSrc,
    input  logic [1:0]       ImmSrc,
    input  logic [1:0]       ALUControl,
    input  logic [WIDTH-1:0] ReadData,
    output logic [WIDTH-1:0] Adr,
    output logic [WIDTH-1:0] WriteData,
    output logic [WIDTH-1:0] Instr,
    output logic [3:0]       ALUFlags
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] wd_q, wd_d;
    logic [WIDTH-1:0] aluout_q, aluout_d;
    logic [WIDTH-1:0] rf_q [NREGS];
    logic [WIDTH-1:0] rf_d [NREGS];

    logic [3:0]       ra1, ra2, wa;
    logic [WIDTH-1:0] rd1, rd2;
    logic [WIDTH-1:0] ext_imm;
    logic [WIDTH-1:0] src_a, src_b, src_b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_result;
    logic             alu_c, alu_v;
    logic [WIDTH-1:0] result;
    logic             unused_memwrite;

    assign unused_memwrite = MemWrite;

    assign ra1 = RegSrc[0] ? 4'd15 : ir_q[19:16];
    assign ra2 = RegSrc[1] ? ir_q[15:12] : ir_q[3:0];
    assign wa  = ir_q[15:12];

    // R15 is not stored; it aliases the current Result (PC+8 during decode)
    assign rd1 = (ra1 == 4'd15) ? result : rf_q[ra1];
    assign rd2 = (ra2 == 4'd15) ? result : rf_q[ra2];

    always_comb begin
        ext_imm = '0;
        unique case (ImmSrc)
            2'b00: ext_imm = {24'b0, ir_q[7:0]};
            2'b01: ext_imm = {20'b0, ir_q[11:0]};
            2'b10: ext_imm = {{6{ir_q[23]}}, ir_q[23:0], 2'b00};
            2'b11: ext_imm = '0;
        endcase
    end

    always_comb begin
        src_a = '0;
        unique case (ALUSrcA)
            2'b00: src_a = a_q;
            2'b01: src_a = pc_q;
            2'b10: src_a = aluout_q;
            2'b11: src_a = '0;
        endcase
    end

    always_comb begin
        src_b = '0;
        unique case (ALUSrcB)
            2'b00: src_b = wd_q;
            2'b01: src_b = ext_imm;
            2'b10: src_b = 32'd4;
            2'b11: src_b = '0;
        endcase
    end

    assign src_b_eff = ALUControl[0] ? ~src_b : src_b;
    assign sum = {1'b0, src_a} + {1'b0, src_b_eff}
               + {{WIDTH{1'b0}}, ALUControl[0]};

    always_comb begin
        alu_result = sum[WIDTH-1:0];
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        unique case (ALUControl)
            2'b00, 2'b01: begin
                alu_c = sum[WIDTH];
                alu_v = (src_a[WIDTH-1] == src_b_eff[WIDTH-1])
                      && (sum[WIDTH-1] != src_a[WIDTH-1]);
            end
            2'b10: alu_result = src_a & src_b;
            2'b11: alu_result = src_a | src_b;
        endcase
    end

    assign ALUFlags = {alu_result[WIDTH-1], alu_result == '0, alu_c, alu_v};

    always_comb begin
        result = aluout_q;
        unique case (ResultSrc)
            2'b01:        result = data_q;
            2'b10:        result = alu_result;
            2'b00, 2'b11: result = aluout_q;
        endcase
    end

    assign Adr       = AdrSrc ? result : pc_q;
    assign Instr     = ir_q;
    assign WriteData = wd_q;

    always_comb begin
        pc_d     = PCWrite ? result : pc_q;
        ir_d     = IRWrite ? ReadData : ir_q;
        data_d   = ReadData;
        a_d      = rd1;
        wd_d     = rd2;
        aluout_d = alu_result;
        for (int i = 0; i < NREGS; i++) begin
            rf_d[i] = rf_q[i];
            if (RegWrite && wa == 4'(i))
                rf_d[i] = result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= '0;
            ir_q     <= '0;
            data_q   <= '0;
            a_q      <= '0;
            wd_q     <= '0;
            aluout_q <= '0;
            for (int i = 0; i < NREGS; i++)
                rf_q[i] <= '0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            data_q   <= data_d;
            a_q      <= a_d;
            wd_q     <= wd_d;
            aluout_q <= aluout_d;
            for (int i = 0; i < NREGS; i++)
                rf_q[i] <= rf_d[i];
        end
    end

endmodule

// File: tb/tb_arm_multicycle_datapath.sv
// Directed + randomized bench for arm_multicycle_datapath.
// Reference: register array plus plain 64-bit arithmetic for ALU results and flags.
module tb_arm_multicycle_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
    logic [31:0] ReadData;
    logic [31:0] Adr, WriteData, Instr;
    logic [3:0]  ALUFlags;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] regs_m [15];
    logic [31:0] pc_m;

    arm_multicycle_datapath dut (
        .clk(clk), .reset(reset),
        .PCWrite(PCWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .IRWrite(IRWrite),
        .AdrSrc(AdrSrc), .RegSrc(RegSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .ReadData(ReadData),
        .Adr(Adr), .WriteData(WriteData),
        .Instr(Instr), .ALUFlags(ALUFlags)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic quiet();
        PCWrite = 0; RegWrite = 0; IRWrite = 0; MemWrite = 0;
        AdrSrc = 0; RegSrc = 2'b00; ImmSrc = 2'b00;
        ALUSrcA = 2'b11; ALUSrcB = 2'b11;
        ResultSrc = 2'b10; ALUControl = 2'b00;
    endtask

    function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b,
                                    input logic [1:0] op,
                                    output logic [31:0] r,
                                    output logic [3:0] f);
        longint sa, sb, ss;
        logic   c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c = 1'b0;
        v = 1'b0;
        case (op)
            2'b00: begin
                r  = a + b;
                c  = ((64'(a) + 64'(b)) >> 32) != 0;
                ss = sa + sb;
                v  = ss != longint'($signed(r));
            end
            2'b01: begin
                r  = a - b;
                c  = a >= b;
                ss = sa - sb;
                v  = ss != longint'($signed(r));
            end
            2'b10: r = a & b;
            default: r = a | b;
        endcase
        f = {r[31], r == 32'h0, c, v};
    endfunction

    task automatic load_ir(input logic [31:0] v);
        IRWrite = 1; ReadData = v;
        tick();
        IRWrite = 0;
    endtask

    task automatic write_reg(input logic [3:0] rd, input logic [31:0] v);
        load_ir({16'h0, rd, 12'h0});
        ReadData = v;
        tick();
        ResultSrc = 2'b01; RegWrite = 1;
        tick();
        RegWrite = 0; ResultSrc = 2'b10;
        if (rd != 4'd15) regs_m[rd] = v;
    endtask

    task automatic read_reg(input logic [3:0] idx, input string tag);
        load_ir({12'h0, idx, idx, 12'h0});
        RegSrc = 2'b10;
        tick();
        ALUSrcA = 2'b00; ALUSrcB = 2'b11;
        ALUControl = 2'b00; ResultSrc = 2'b10; AdrSrc = 1;
        settle();
        chk({tag, "_rd2"}, WriteData, regs_m[idx]);
        chk({tag, "_rd1"}, Adr, regs_m[idx]);
        quiet();
    endtask

    task automatic fetch(input logic [31:0] instr, input string tag);
        AdrSrc = 0; IRWrite = 1; ReadData = instr;
        ALUSrcA = 2'b01; ALUSrcB = 2'b10;
        ResultSrc = 2'b10; ALUControl = 2'b00; PCWrite = 1;
        settle();
        chk({tag, "_adr_pre"}, Adr, pc_m);
        tick();
        PCWrite = 0; IRWrite = 0;
        pc_m = pc_m + 32'd4;
        settle();
        chk({tag, "_instr"}, Instr, instr);
        chk({tag, "_adr_post"}, Adr, pc_m);
    endtask

    task automatic alu_check(input string tag, input logic [31:0] a,
                             input logic [31:0] b, input logic [1:0] op,
                             input bit use_want, input logic [3:0] want);
        logic [3:0]  rn, rm;
        logic [31:0] r;
        logic [3:0]  f;
        rn = 4'($urandom_range(0, 14));
        rm = 4'((int'(rn) + int'($urandom_range(1, 14))) % 15);
        write_reg(rn, a);
        write_reg(rm, b);
        load_ir({12'h0, rn, 4'h0, 8'h0, rm});
        RegSrc = 2'b00;
        tick();
        ALUSrcA = 2'b00; ALUSrcB = 2'b00; ALUControl = op;
        ResultSrc = 2'b10; AdrSrc = 1;
        settle();
        ref_alu(a, b, op, r, f);
        chk({tag, "_res"}, Adr, r);
        chk({tag, "_flags"}, {28'h0, ALUFlags}, {28'h0, f});
        if (use_want) chk({tag, "_spec"}, {28'h0, ALUFlags}, {28'h0, want});
        quiet();
    endtask

    task automatic apply_reset();
        reset = 1; PCWrite = 1; RegWrite = 1; IRWrite = 1;
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        ReadData = 32'hFFFF_FFFF;
        tick();
        tick();
        reset = 0;
        quiet();
        pc_m = 32'h0;
        for (int i = 0; i < 15; i++) regs_m[i] = 32'h0;
        settle();
    endtask

    initial begin
        logic [31:0] a, b;
        logic [1:0]  op;

        quiet();
        ReadData = 32'h0;
        apply_reset();
        chk("reset_instr", Instr, 32'h0);
        chk("reset_adr", Adr, 32'h0);
        chk("reset_wd", WriteData, 32'h0);

        write_reg(4'd2, 32'h1234_5678);
        write_reg(4'd14, 32'hCAFE_F00D);
        read_reg(4'd2, "pre_r2");
        fetch(32'hE081_2002, "pre_fetch");

        apply_reset();
        chk("reset2_instr", Instr, 32'h0);
        chk("reset2_adr", Adr, 32'h0);
        chk("reset2_wd", WriteData, 32'h0);

        fetch(32'hE280_1005, "fetch");

        for (int i = 0; i < 15; i++)
            read_reg(4'(i), $sformatf("rst_r%0d", i));

        write_reg(4'd0, 32'd7);
        load_ir(32'hE280_1005);
        RegSrc = 2'b00;
        tick();
        ImmSrc = 2'b00; ALUSrcA = 2'b00; ALUSrcB = 2'b01;
        ALUControl = 2'b00; ResultSrc = 2'b10; AdrSrc = 1;
        settle();
        chk("addi_res", Adr, 32'd12);
        chk("addi_flags", {28'h0, ALUFlags}, 32'h0);
        tick();
        ResultSrc = 2'b00; RegWrite = 1;
        tick();
        quiet();
        regs_m[1] = 32'd12;
        read_reg(4'd1, "addi_r1");

        alu_check("sub_eq", 32'd5, 32'd5, 2'b01, 1, 4'b0110);
        alu_check("sub_ovf", 32'h8000_0000, 32'd1, 2'b01, 1, 4'b0011);
        alu_check("sub_neg", 32'd0, 32'd1, 2'b01, 1, 4'b1000);

        fetch(32'hEAFF_FFFE, "bfetch");
        RegSrc = 2'b01; ALUSrcA = 2'b01; ALUSrcB = 2'b10;
        ResultSrc = 2'b10; ALUControl = 2'b00;
        tick();
        RegSrc = 2'b00; ALUSrcA = 2'b00; ALUSrcB = 2'b01;
        ImmSrc = 2'b10; PCWrite = 1; AdrSrc = 1;
        settle();
        chk("br_target", Adr, 32'd4);
        tick();
        PCWrite = 0; AdrSrc = 0;
        pc_m = 32'd4;
        settle();
        chk("br_pc", Adr, pc_m);
        ALUSrcA = 2'b01; RegWrite = 1;
        tick();
        RegWrite = 0;
        settle();
        chk("r15_write_pc", Adr, pc_m);

        load_ir(32'h0000_5000);
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        ALUControl = 2'b00;
        PCWrite = 1; RegWrite = 1; IRWrite = 1;
        ReadData = 32'h0000_6000;
        tick();
        quiet();
        pc_m = 32'd8;
        regs_m[5] = 32'd8;
        settle();
        chk("simul_instr", Instr, 32'h0000_6000);
        chk("simul_pc", Adr, pc_m);
        read_reg(4'd5, "simul_r5");

        load_ir(32'hE590_3040);
        ALUSrcA = 2'b11; ALUSrcB = 2'b01; ImmSrc = 2'b00;
        ALUControl = 2'b00; ResultSrc = 2'b10; AdrSrc = 1;
        ReadData = 32'hDEAD_BEEF;
        settle();
        chk("ls_adr", Adr, 32'h40);
        tick();
        ReadData = 32'h0; ResultSrc = 2'b01; RegWrite = 1;
        RegSrc = 2'b10; AdrSrc = 0;
        tick();
        chk("ls_wd_old", WriteData, regs_m[3]);
        RegWrite = 0;
        regs_m[3] = 32'hDEAD_BEEF;
        tick();
        chk("ls_wd_new", WriteData, 32'hDEAD_BEEF);
        quiet();

        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            b = $urandom;
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0: b = a;
                1: a = 32'h8000_0000;
                2: b = 32'h7FFF_FFFF;
                default: ;
            endcase
            alu_check($sformatf("rnd%0d", i), a, b, op, 0, 4'h0);
        end

        for (int i = 0; i < 15; i++)
            read_reg(4'(i), $sformatf("final_r%0d", i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arm_multicycle_datapath.md
Name: arm_multicycle_datapath

Overview:
32-bit datapath of the multicycle ARM core. It executes the control word issued each cycle by the core controller and returns the fetched instruction and the ALU condition flags. It holds PC, IR, the memory data register, the A/B operand registers, ALUOut and a 15-entry register file. A single unified memory sits outside the block, addressed by Adr.

Parameters:
WIDTH, 32, datapath and memory word width (only 32 is supported)
NREGS, 15, architected general registers R0-R14; R15 is virtual

Ports:
clk  input  1  core clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
PCWrite  input  1  load PC from Result
MemWrite  input  1  forwarded to memory; no internal state effect
RegWrite  input  1  write Result into register Instr[15:12]
IRWrite  input  1  load IR from ReadData
AdrSrc  input  1  memory address select: 0 = PC, 1 = Result
RegSrc  input  2  [0]: RA1 = 15; [1]: RA2 = Instr[15:12]
ALUSrcA  input  2  00 A, 01 PC, 10 ALUOut, 11 zero
ALUSrcB  input  2  00 WriteData, 01 ExtImm, 10 constant 4, 11 zero
ResultSrc  input  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ALUOut
ImmSrc  input  2  immediate format select
ALUControl  input  2  00 ADD, 01 SUB, 10 AND, 11 ORR
ReadData  input  32  memory read data
Adr  output  32  memory address
WriteData  output  32  B register, memory write data
Instr  output  32  IR contents; controller consumes [31:12]
ALUFlags  output  4  {N,Z,C,V} of the current combinational ALU result

Behaviour:
- Reset (synchronous, highest priority over every enable): PC, IR, Data, A, WriteData and ALUOut are set to 0, and all 15 registers are set to 0.
- Reset values of outputs: Adr = 0 (with AdrSrc = 0), Instr = 0, WriteData = 0. ALUFlags follow the combinational ALU.
- PC: PC <= Result when PCWrite = 1, otherwise it holds.
- IR: IR <= ReadData when IRWrite = 1, otherwise it holds. Instr = IR.
- Data register: Data <= ReadData every cycle, with no enable.
- A <= RD1, WriteData <= RD2 and ALUOut <= ALUResult every cycle, with no enable.
- Register file read addresses: RA1 = RegSrc[0] ? 4'd15 : Instr[19:16]; RA2 = RegSrc[1] ? Instr[15:12] : Instr[3:0].
- Register file reads are combinational. Reading address 15 returns the current Result, which yields PC+8 in the decode cycle.
- Register file write: on the rising edge with RegWrite = 1, register Instr[15:12] <= Result. A write to address 15 is ignored; only PCWrite changes PC.
- Same-cycle read and write of one register: the read returns the old value, and the new value is visible the next cycle.
- Extend:
  - ImmSrc 00: zero-extend Instr[7:0].
  - ImmSrc 01: zero-extend Instr[11:0].
  - ImmSrc 10: sign-extend Instr[23:0], shifted left by 2.
  - ImmSrc 11: 0.
- ALU, 32-bit:
  - ADD: sum = SrcA + SrcB.
  - SUB: sum = SrcA + ~SrcB + 1.
  - N = result[31]; Z = (result == 0).
  - ADD/SUB: C = carry out of bit 31, so for SUB C = 1 means no borrow. V = operands of like sign (after inversion for SUB) whose result sign differs.
  - AND/ORR: C = 0, V = 0.
- Result mux per ResultSrc (11 is reserved and aliases 00). Adr = AdrSrc ? Result : PC.
- Simultaneous PCWrite, RegWrite and IRWrite in one cycle are legal. Each register samples the pre-edge Result or ReadData.
- Reset asserted mid-instruction discards all in-flight state. The first cycle after reset deasserts is a fetch from address 0.

Test Plan:
- Reset: hold reset 2 cycles with PCWrite = 1 and RegWrite = 1 -> after release PC = 0, Instr = 0, Adr = 0, and all registers read 0.
- Fetch: AdrSrc = 0, IRWrite = 1, ALUSrcA = 01, ALUSrcB = 10, ResultSrc = 10, PCWrite = 1, ReadData = 0xE2801005 -> next cycle Instr = 0xE2801005, PC = 4, Adr = 4.
- ADD immediate: R0 = 7, Instr = 0xE2801005, ImmSrc = 00, SrcA = A, SrcB = ExtImm, ADD, then ResultSrc = 00 with RegWrite -> R1 = 12, ALUFlags = 0000.
- SUB flags:
  - A = 5, B = 5, SUB -> ALUFlags = 0110 (Z, C).
  - A = 0x80000000, B = 1, SUB -> ALUFlags = 0011 (C, V).
  - A = 0, B = 1, SUB -> ALUFlags = 1000.
- Branch: PC = 8, Instr[23:0] = 0xFFFFFE, ImmSrc = 10, RA1 = 15 with Result = 12, ADD, PCWrite -> PC = 4; a RegWrite with Instr[15:12] = 15 leaves PC unchanged.
- Load/store: AdrSrc = 1 with Result = 0x40 -> Adr = 0x40; next cycle ReadData = 0xDEADBEEF, ResultSrc = 01, RegWrite with Rd = 3 -> R3 = 0xDEADBEEF; WriteData tracks RD2 one cycle later.
